// File: rtl/uart_message_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_message_receiver
// Brief    : 8N1 UART receiver assembling three bytes into a 20-bit message.
// Revision : 1.0
// ============================================================================
module uart_message_receiver #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        serialIn,
    output logic        isNew,
    output logic [19:0] message,
    output logic        frameError
);

    localparam int c_half  = CLKS_PER_BIT / 2;
    localparam int c_cnt_w = $clog2(CLKS_PER_BIT * TIMEOUT_BITS + 1);
    localparam logic [c_cnt_w-1:0] c_half_last    = c_cnt_w'(c_half - 1);
    localparam logic [c_cnt_w-1:0] c_bit_last     = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(CLKS_PER_BIT * TIMEOUT_BITS - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one      = c_cnt_w'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic [1:0]           r_byte_idx;
    logic [15:0]          r_staging;
    logic [19:0]          r_message;
    logic                 r_is_new;
    logic                 r_frame_err;

    logic w_cnt_clr;
    logic w_cnt_inc;
    logic w_shift_en;
    logic w_byte_ok;
    logic w_stop_err;
    logic w_timeout;
    logic w_msg_ok;
    logic w_msg_bad;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The shared counter times bit sampling and, in IDLE, the inter-byte gap.
    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_shift_en   = 1'b0;
        w_byte_ok    = 1'b0;
        w_stop_err   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_next = S_START;
                    w_cnt_clr    = 1'b1;
                end else if (r_byte_idx != 2'd0) begin
                    if (r_cnt == c_timeout_last) begin
                        w_timeout = 1'b1;
                        w_cnt_clr = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end else begin
                    w_cnt_clr = 1'b1;
                end
            end
            S_START: begin
                if (r_cnt == c_half_last) begin
                    w_cnt_clr    = 1'b1;
                    w_state_next = r_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_DATA: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_STOP: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_clr = 1'b1;
                    if (r_rx_s) begin
                        w_byte_ok    = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_stop_err   = 1'b1;
                        w_state_next = S_BREAK;
                    end
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_BREAK: begin
                w_cnt_clr = 1'b1;
                if (r_rx_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_clr    = 1'b1;
            end
        endcase
    end

    assign w_msg_ok  = w_byte_ok && (r_byte_idx == 2'd2) && (r_shift[7:4] == 4'd0);
    assign w_msg_bad = w_byte_ok && (r_byte_idx == 2'd2) && (r_shift[7:4] != 4'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'd0;
            r_byte_idx  <= 2'd0;
            r_staging   <= 16'd0;
            r_message   <= 20'd0;
            r_is_new    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_meta <= serialIn;
            r_rx_s    <= r_rx_meta;

            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + c_cnt_one;
            end

            if (r_state == S_START) begin
                r_bit_idx <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_shift_en) begin
                r_shift <= {r_rx_s, r_shift[7:1]};
            end

            r_is_new    <= w_msg_ok;
            r_frame_err <= w_stop_err | w_timeout | w_msg_bad;

            if (w_stop_err || w_timeout) begin
                r_byte_idx <= 2'd0;
            end else if (w_byte_ok) begin
                case (r_byte_idx)
                    2'd0: begin
                        r_staging[7:0] <= r_shift;
                        r_byte_idx     <= 2'd1;
                    end
                    2'd1: begin
                        r_staging[15:8] <= r_shift;
                        r_byte_idx      <= 2'd2;
                    end
                    default: r_byte_idx <= 2'd0;
                endcase
            end

            if (w_msg_ok) begin
                r_message <= {r_shift[3:0], r_staging};
            end
        end
    end

    assign isNew      = r_is_new;
    assign message    = r_message;
    assign frameError = r_frame_err;

endmodule
`default_nettype wire
